bip_run_controller: RTL



---
 rtl/bip_run_controller_pkg.sv | 39 +++
 rtl/bip_sat_counter.sv | 24 ++
 rtl/bip_run_controller.sv | 91 +++++++++
 3 files changed

// File: rtl/bip_run_controller_pkg.sv
// Shared definitions for the BIP run/debug sequencer: state codes, command
// defaults, dump layout and the snapshot byte selector.
package bip_run_controller_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;

    localparam logic [7:0] START_CMD_DEF   = 8'h73;
    localparam logic [7:0] ABORT_CMD_DEF   = 8'h61;
    localparam logic [4:0] HALT_OPCODE_DEF = 5'b00000;

    localparam int unsigned DUMP_BYTES = 6;

    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] acc;
        logic [15:0] pc;
    } snapshotT;

    // Little-endian dump order: pc, acc, cycle count.
    function automatic logic [7:0] dumpByte(input snapshotT snap, input logic [2:0] idx);
        logic [7:0] b;
        b = '0;
        case (idx)
            3'd0:    b = snap.pc[7:0];
            3'd1:    b = snap.pc[15:8];
            3'd2:    b = snap.acc[7:0];
            3'd3:    b = snap.acc[15:8];
            3'd4:    b = snap.cnt[7:0];
            3'd5:    b = snap.cnt[15:8];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bip_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module bip_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] countNext
);

    // Holds at all-ones instead of wrapping.
    assign countNext = (count == '1) ? count : count + W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= countNext;
        end
    end

endmodule

// File: rtl/bip_run_controller.sv
// Run/debug sequencer between the UART byte interfaces and the BIP core:
// start on command, count cycles until HALT/abort, then dump PC/ACC/count.
module bip_run_controller
    import bip_run_controller_pkg::*;
#(
    parameter logic [7:0]  START_CMD   = START_CMD_DEF,
    parameter logic [7:0]  ABORT_CMD   = ABORT_CMD_DEF,
    parameter logic [4:0]  HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int unsigned PC_W        = 11,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_done,
    input  logic [4:0]       opcode,
    input  logic [PC_W-1:0]  pc,
    input  logic [ACC_W-1:0] acc,
    output logic             cpu_en,
    output logic             cpu_clr,
    output logic             busy
);

    logic [2:0]       state;
    logic [2:0]       stateNext;
    logic [2:0]       byteIdx;
    snapshotT         snap;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] cycleCntNext;
    logic             startHit;
    logic             stopRun;
    logic             lastByte;

    bip_sat_counter #(
        .W(CNT_W)
    ) cycleCounter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == CLEAR),
        .en       (state == RUN),
        .count    (cycleCnt),
        .countNext(cycleCntNext)
    );

    assign startHit = rx_done && (rx_data == START_CMD);
    // Halt wins over a coincident abort; both lead to the same snapshot.
    assign stopRun  = (opcode == HALT_OPCODE) || (rx_done && (rx_data == ABORT_CMD));
    assign lastByte = (byteIdx == 3'(DUMP_BYTES - 1));

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startHit) stateNext = CLEAR;
            CLEAR:   stateNext = RUN;
            RUN:     if (stopRun) stateNext = SEND;
            SEND:    stateNext = WAIT;
            WAIT:    if (tx_done) stateNext = lastByte ? IDLE : SEND;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            byteIdx <= '0;
            snap    <= '0;
        end else begin
            state <= stateNext;
            if (state == RUN && stopRun) begin
                // The stopping cycle is itself counted, hence the look-ahead value.
                snap.cnt <= 16'(cycleCntNext);
                snap.acc <= 16'(acc);
                snap.pc  <= 16'(pc);
                byteIdx  <= '0;
            end else if (state == WAIT && tx_done && !lastByte) begin
                byteIdx <= byteIdx + 3'd1;
            end
        end
    end

    assign cpu_en   = (state == RUN);
    assign cpu_clr  = (state == CLEAR);
    assign tx_start = (state == SEND);
    assign busy     = (state != IDLE);
    assign tx_data  = dumpByte(snap, byteIdx);

endmodule
